// File: rtl/updown_mod_counter_pkg.sv
// Shared encodings for the up/down modulo counter: count modes, direction and FSM states.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [0:0] state_t;
    localparam state_t ST_RUN     = 1'b0;
    localparam state_t ST_EXPIRED = 1'b1;

endpackage

// File: rtl/updown_mod_counter_prescaler.sv
// Divides ENABLE by PRESCALE: TICK is high on every PRESCALE-th cycle with ENABLE=1.
module enable_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic CLEAR,
    input  logic ENABLE,
    output logic TICK
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;

    assign TICK = ENABLE && (cnt_q == LAST);

    always_ff @(posedge CLOCK) begin
        if (!RESET || CLEAR) begin
            cnt_q <= '0;
        end else if (ENABLE) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate/one-shot modes and a registered TC pulse.
// Optional ENABLE prescaler is built only when COUNTER_PRESCALE_EN is defined.
//
// state      | meaning
// ST_RUN     | normal counting
// ST_EXPIRED | one-shot reached its terminal value; COUNT frozen, DONE=1
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MOD_MAX   = 255,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic             UP_DOWN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    state_t           state_q;
    logic             sat_fired_q;
    logic             dir_q;
    logic             step;

`ifdef COUNTER_PRESCALE_EN
    enable_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .CLEAR  (LOAD),
        .ENABLE (ENABLE),
        .TICK   (step)
    );
`else
    assign step = ENABLE;
`endif

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] next_val;
    logic             at_term;
    logic             sat_fired_eff;

    assign load_val = (DATA > MAX_V) ? MAX_V : DATA;
    assign term_val = (UP_DOWN == DIR_UP) ? MAX_V : '0;
    assign wrap_val = (UP_DOWN == DIR_UP) ? '0 : MAX_V;
    assign next_val = (UP_DOWN == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    assign at_term  = (count_q == term_val);
    // A direction change rearms the saturate TC even if COUNT has not moved.
    assign sat_fired_eff = sat_fired_q && (UP_DOWN == dir_q);

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            count_q     <= RST_V;
            tc_q        <= 1'b0;
            state_q     <= ST_RUN;
            sat_fired_q <= 1'b0;
            dir_q       <= DIR_UP;
        end else begin
            tc_q        <= 1'b0;
            dir_q       <= UP_DOWN;
            sat_fired_q <= sat_fired_eff;
            if (LOAD) begin
                count_q     <= load_val;
                state_q     <= ST_RUN;
                sat_fired_q <= 1'b0;
            end else if (state_q == ST_EXPIRED) begin
                if (MODE != MODE_ONESHOT) begin
                    state_q <= ST_RUN;
                end
            end else if (step) begin
                if (!at_term) begin
                    count_q     <= next_val;
                    sat_fired_q <= 1'b0;
                end else begin
                    case (MODE)
                        MODE_SAT: begin
                            tc_q        <= !sat_fired_eff;
                            sat_fired_q <= 1'b1;
                        end
                        MODE_ONESHOT: begin
                            tc_q    <= 1'b1;
                            state_q <= ST_EXPIRED;
                        end
                        default: begin
                            count_q     <= wrap_val;
                            tc_q        <= 1'b1;
                            sat_fired_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign COUNT = count_q;
    assign TC    = tc_q;
    assign DONE  = (state_q == ST_EXPIRED);

endmodule
